// File: rtl/mem_stage_pkg.sv
// Shared types and extension helpers for the memory-access stage.
package mem_stage_pkg;

  // Field layout of the EXE->MEM payload, MSB first.
  typedef struct packed {
    logic        ld_b;
    logic        ld_bu;
    logic        ld_h;
    logic        ld_hu;
    logic        ld_w;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] exe_result;
    logic [31:0] pc;
  } es_to_ms_t;

  // Field layout of the MEM->WB payload, MSB first.
  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] zext8(input logic [7:0] v);
    return {24'h000000, v};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Byte/halfword/word selection and extension of load data.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr,
  input  logic        ld_b,
  input  logic        ld_bu,
  input  logic        ld_h,
  input  logic        ld_hu,
  input  logic        ld_w,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte lane and halfword (addr[0] ignored for halves: aligned only).
  always_comb begin
    byte_s = 8'h00;
    case (addr)
      2'd0:    byte_s = mem_rdata[7:0];
      2'd1:    byte_s = mem_rdata[15:8];
      2'd2:    byte_s = mem_rdata[23:16];
      2'd3:    byte_s = mem_rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr[1]) begin
      half_s = mem_rdata[31:16];
    end else begin
      half_s = mem_rdata[15:0];
    end
  end

  // Size flags resolved by fixed priority; a load with no flag returns the full word.
  always_comb begin
    load_data = mem_rdata;
    if (ld_b) begin
      load_data = sext8(byte_s);
    end else if (ld_bu) begin
      load_data = zext8(byte_s);
    end else if (ld_h) begin
      load_data = sext16(half_s);
    end else if (ld_hu) begin
      load_data = zext16(half_s);
    end else if (ld_w) begin
      load_data = mem_rdata;
    end else begin
      load_data = mem_rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the EXE payload, captures SRAM load
// data, extracts/extends it and hands the result to WB and the bypass network.
`define ES_TO_MS_BUS_WD 76
`define MS_TO_WS_BUS_WD 70

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ws_allowin,
  output logic                           ms_allowin,
  input  logic                           es_to_ms_valid,
  input  logic [`ES_TO_MS_BUS_WD-1:0]    es_to_ms_bus,
  input  logic [31:0]                    data_sram_rdata,
  output logic                           ms_to_ws_valid,
  output logic [`MS_TO_WS_BUS_WD-1:0]    ms_to_ws_bus,
  output logic [4:0]                     MEM_dest,
  output logic                           mem_gr_we,
  output logic [31:0]                    MEM_result
);

  logic        ms_valid_r;
  es_to_ms_t   bus_r;
  logic [31:0] rdata_r;
  logic        first_r;

  logic        ms_ready_go_s;
  logic        ms_allowin_s;
  logic        accept_s;
  logic [31:0] mem_rdata_s;
  logic [31:0] load_data_s;
  logic [31:0] final_result_s;
  ms_to_ws_t   ws_bus_s;

  assign ms_ready_go_s = 1'b1;
  assign ms_allowin_s  = !ms_valid_r || (ms_ready_go_s && ws_allowin);
  assign accept_s      = es_to_ms_valid && ms_allowin_s;

  // Stage occupancy: advances whenever the stage can take a new payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_r <= 1'b0;
    end else if (ms_allowin_s) begin
      ms_valid_r <= es_to_ms_valid;
    end
  end

  // Payload register and first-cycle marker; the marker is high only in the
  // cycle where the SRAM output belongs to the instruction now in MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_r   <= es_to_ms_t'({`ES_TO_MS_BUS_WD{1'b0}});
      first_r <= 1'b0;
    end else if (accept_s) begin
      bus_r   <= es_to_ms_t'(es_to_ms_bus);
      first_r <= 1'b1;
    end else begin
      first_r <= 1'b0;
    end
  end

  // Hold load data across WB stalls, since the SRAM output is not kept stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= 32'h0000_0000;
    end else if (first_r) begin
      rdata_r <= data_sram_rdata;
    end
  end

  // Live SRAM data in the first cycle, held copy afterwards.
  always_comb begin
    if (first_r) begin
      mem_rdata_s = data_sram_rdata;
    end else begin
      mem_rdata_s = rdata_r;
    end
  end

  mem_load_align u_load_align (
    .mem_rdata (mem_rdata_s),
    .addr      (bus_r.exe_result[1:0]),
    .ld_b      (bus_r.ld_b),
    .ld_bu     (bus_r.ld_bu),
    .ld_h      (bus_r.ld_h),
    .ld_hu     (bus_r.ld_hu),
    .ld_w      (bus_r.ld_w),
    .load_data (load_data_s)
  );

  // Result selection between load data and the ALU result.
  always_comb begin
    if (bus_r.res_from_mem) begin
      final_result_s = load_data_s;
    end else begin
      final_result_s = bus_r.exe_result;
    end
  end

  // WB payload and handshake.
  always_comb begin
    ws_bus_s.gr_we  = bus_r.gr_we;
    ws_bus_s.dest   = bus_r.dest;
    ws_bus_s.result = final_result_s;
    ws_bus_s.pc     = bus_r.pc;
    ms_to_ws_bus    = ws_bus_s;
    ms_to_ws_valid  = ms_valid_r && ms_ready_go_s;
    ms_allowin      = ms_allowin_s;
  end

  // Forwarding outputs, gated so a drained stage never matches a hazard.
  always_comb begin
    if (ms_valid_r) begin
      MEM_dest   = bus_r.dest;
      mem_gr_we  = bus_r.gr_we;
      MEM_result = final_result_s;
    end else begin
      MEM_dest   = 5'd0;
      mem_gr_we  = 1'b0;
      MEM_result = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a WB-side scoreboard.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [75:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [4:0]  MEM_dest;
  logic        mem_gr_we;
  logic [31:0] MEM_result;

  int checks = 0;
  int errors = 0;
  logic [69:0] exp_q[$];

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_B    = 5'b10000;
  localparam logic [4:0] F_BU   = 5'b01000;
  localparam logic [4:0] F_H    = 5'b00100;
  localparam logic [4:0] F_HU   = 5'b00010;
  localparam logic [4:0] F_W    = 5'b00001;
  localparam logic [31:0] RD    = 32'h80FF7F01;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .MEM_dest        (MEM_dest),
    .mem_gr_we       (mem_gr_we),
    .MEM_result      (MEM_result)
  );

  always #5 clk = ~clk;

  function automatic logic [75:0] mk_bus(input logic [4:0] flags, input logic rfm, input logic we,
                                         input logic [4:0] dest, input logic [31:0] res, input logic [31:0] pc);
    return {flags, rfm, we, dest, res, pc};
  endfunction

  function automatic logic [69:0] mk_exp(input logic we, input logic [4:0] dest,
                                         input logic [31:0] res, input logic [31:0] pc);
    return {we, dest, res, pc};
  endfunction

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs, then at the falling edge score any WB delivery.
  task automatic drive(input logic ev, input logic [75:0] bus, input logic [31:0] rd, input logic wsa);
    logic [69:0] e;
    es_to_ms_valid  = ev;
    es_to_ms_bus    = bus;
    data_sram_rdata = rd;
    ws_allowin      = wsa;
    @(negedge clk);
    if (ms_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        check("unexpected_delivery", {69'd0, ms_to_ws_valid}, 70'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_payload", ms_to_ws_bus, e);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = 76'd0;
    data_sram_rdata = 32'd0;
    ws_allowin = 1'b0;
    adv();
    @(negedge clk);
    check("rst_valid", ms_to_ws_valid, 1'b0);
    check("rst_bus", ms_to_ws_bus, 70'd0);
    check("rst_dest", MEM_dest, 5'd0);
    check("rst_gr_we", mem_gr_we, 1'b0);
    check("rst_result", MEM_result, 32'd0);
    check("rst_allowin", ms_allowin, 1'b1);
    adv();
    reset = 1'b0;

    // ld_b at addr 3, single cycle to WB, then stage drains.
    exp_q.push_back(mk_exp(1'b1, 5'd5, 32'hFFFFFF80, 32'h1c000010));
    drive(1'b1, mk_bus(F_B, 1'b1, 1'b1, 5'd5, 32'h00002003, 32'h1c000010), 32'h0, 1'b1);
    adv();
    drive(1'b0, 76'd0, RD, 1'b1);
    check("ldb_result", MEM_result, 32'hFFFFFF80);
    check("ldb_gr_we", mem_gr_we, 1'b1);
    check("ldb_dest", MEM_dest, 5'd5);
    adv();
    drive(1'b0, 76'd0, RD, 1'b1);
    check("drain_valid", ms_to_ws_valid, 1'b0);
    check("drain_dest", MEM_dest, 5'd0);
    check("drain_gr_we", mem_gr_we, 1'b0);
    check("drain_result", MEM_result, 32'd0);
    adv();

    // Back-to-back loads of assorted sizes against the same word.
    exp_q.push_back(mk_exp(1'b1, 5'd1, 32'h00000080, 32'h1c000020));
    drive(1'b1, mk_bus(F_BU, 1'b1, 1'b1, 5'd1, 32'h00003003, 32'h1c000020), 32'h0, 1'b1);
    adv();
    exp_q.push_back(mk_exp(1'b1, 5'd2, 32'h000080FF, 32'h1c000024));
    drive(1'b1, mk_bus(F_HU, 1'b1, 1'b1, 5'd2, 32'h00003002, 32'h1c000024), RD, 1'b1);
    adv();
    exp_q.push_back(mk_exp(1'b1, 5'd3, 32'hFFFF80FF, 32'h1c000028));
    drive(1'b1, mk_bus(F_H, 1'b1, 1'b1, 5'd3, 32'h00003002, 32'h1c000028), RD, 1'b1);
    adv();
    exp_q.push_back(mk_exp(1'b1, 5'd4, 32'h80FF7F01, 32'h1c00002c));
    drive(1'b1, mk_bus(F_NONE, 1'b1, 1'b1, 5'd4, 32'h00003000, 32'h1c00002c), RD, 1'b1);
    adv();
    exp_q.push_back(mk_exp(1'b1, 5'd6, 32'h0000007F, 32'h1c000030));
    drive(1'b1, mk_bus(F_B | F_H | F_W, 1'b1, 1'b1, 5'd6, 32'h00003001, 32'h1c000030), RD, 1'b1);
    adv();
    exp_q.push_back(mk_exp(1'b1, 5'd8, 32'hFFFFFFFF, 32'h1c000034));
    drive(1'b1, mk_bus(F_B, 1'b1, 1'b1, 5'd8, 32'h00003002, 32'h1c000034), RD, 1'b1);
    adv();
    drive(1'b0, 76'd0, RD, 1'b1);
    adv();

    // Load stalled by WB for three cycles while the SRAM output changes.
    exp_q.push_back(mk_exp(1'b1, 5'd10, 32'h11223344, 32'h1c000040));
    drive(1'b1, mk_bus(F_W, 1'b1, 1'b1, 5'd10, 32'h00004000, 32'h1c000040), 32'h0, 1'b1);
    adv();
    drive(1'b0, 76'd0, 32'h11223344, 1'b0);
    check("stall1_allowin", ms_allowin, 1'b0);
    check("stall1_result", MEM_result, 32'h11223344);
    adv();
    drive(1'b1, mk_bus(F_B, 1'b1, 1'b0, 5'd30, 32'h00009999, 32'h1c0000ff), 32'hDEADBEEF, 1'b0);
    check("stall2_allowin", ms_allowin, 1'b0);
    check("stall2_result", MEM_result, 32'h11223344);
    adv();
    drive(1'b0, 76'd0, 32'hDEADBEEF, 1'b0);
    check("stall3_allowin", ms_allowin, 1'b0);
    check("stall3_result", MEM_result, 32'h11223344);
    check("stall3_valid", ms_to_ws_valid, 1'b1);
    adv();
    drive(1'b0, 76'd0, 32'hDEADBEEF, 1'b1);
    check("stall_release_allowin", ms_allowin, 1'b1);
    adv();

    // ALU op followed by ld_w with no bubble.
    exp_q.push_back(mk_exp(1'b1, 5'd7, 32'h00001234, 32'h1c000050));
    drive(1'b1, mk_bus(F_NONE, 1'b0, 1'b1, 5'd7, 32'h00001234, 32'h1c000050), 32'h0, 1'b1);
    adv();
    exp_q.push_back(mk_exp(1'b1, 5'd9, 32'hCAFEF00D, 32'h1c000054));
    drive(1'b1, mk_bus(F_W, 1'b1, 1'b1, 5'd9, 32'h00000100, 32'h1c000054), 32'h55555555, 1'b1);
    check("b2b_alu_dest", MEM_dest, 5'd7);
    check("b2b_alu_result", MEM_result, 32'h00001234);
    adv();
    drive(1'b0, 76'd0, 32'hCAFEF00D, 1'b1);
    check("b2b_ld_valid", ms_to_ws_valid, 1'b1);
    check("b2b_ld_dest", MEM_dest, 5'd9);
    adv();
    drive(1'b0, 76'd0, 32'h0, 1'b1);
    check("b2b_drain_dest", MEM_dest, 5'd0);
    adv();

    // Reset while a load is stalled in MEM: it must never reach WB.
    drive(1'b1, mk_bus(F_W, 1'b1, 1'b1, 5'd3, 32'h00000200, 32'h1c000060), 32'h0, 1'b1);
    adv();
    drive(1'b0, 76'd0, 32'h77777777, 1'b0);
    check("rstmid_dest_before", MEM_dest, 5'd3);
    adv();
    reset = 1'b1;
    drive(1'b0, 76'd0, 32'h0, 1'b0);
    adv();
    drive(1'b0, 76'd0, 32'h0, 1'b0);
    check("rstmid_valid", ms_to_ws_valid, 1'b0);
    check("rstmid_dest", MEM_dest, 5'd0);
    check("rstmid_allowin", ms_allowin, 1'b1);
    adv();
    reset = 1'b0;
    drive(1'b0, 76'd0, 32'h77777777, 1'b1);
    check("post_rst_valid0", ms_to_ws_valid, 1'b0);
    adv();
    drive(1'b0, 76'd0, 32'h77777777, 1'b1);
    check("post_rst_valid1", ms_to_ws_valid, 1'b0);
    adv();

    check("scoreboard_empty", exp_q.size(), 70'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage LoongArch pipeline, directly downstream of the execute stage.
- Holds the EXE→MEM payload in a pipeline register and receives synchronous data-SRAM read data for loads issued in EXE.
- Performs byte/halfword/word load extraction with sign or zero extension and forwards results to the decode-stage bypass and hazard logic.
- Passes {gr_we, dest, result, pc} to the writeback stage through a valid/allowin handshake.

Parameters:
- None. Bus widths come from shared macros: ES_TO_MS_BUS_WD = 76, MS_TO_WS_BUS_WD = 70.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ws_allowin  in  1  WB can accept
- ms_allowin  out  1  MEM can accept
- es_to_ms_valid  in  1  EXE payload valid
- es_to_ms_bus  in  76  {ld_b[75], ld_bu, ld_h, ld_hu, ld_w[71], res_from_mem[70], gr_we[69], dest[68:64], exe_result[63:32], pc[31:0]}
- data_sram_rdata  in  32  SRAM read data; valid only in the cycle after the EXE request
- ms_to_ws_valid  out  1  payload valid to WB
- ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- MEM_dest  out  5  dest for hazard detection, 0 when stage empty
- mem_gr_we  out  1  ms_valid & gr_we
- MEM_result  out  32  final_result for bypass

Behaviour:
- Reset and handshake:
  - reset: ms_valid=0, bus_r=0, rdata_r=0, first_r=0. All outputs therefore read 0; ms_allowin=1.
  - ms_ready_go = 1.
  - ms_allowin = !ms_valid | ws_allowin.
  - ms_to_ws_valid = ms_valid.
  - When ms_allowin: ms_valid <= es_to_ms_valid.
  - When es_to_ms_valid & ms_allowin: bus_r <= es_to_ms_bus and first_r <= 1.
  - Otherwise first_r <= 0.
- Read-data hold register:
  - first_r marks the first MEM cycle of the current instruction; it is 1 exactly when data_sram_rdata belongs to this instruction.
  - When first_r: rdata_r <= data_sram_rdata.
  - mem_rdata = first_r ? data_sram_rdata : rdata_r.
  - A WB stall of any length must not corrupt load data. The SRAM output may change arbitrarily during the stall.
- Load extraction (in sub-module):
  - a = exe_result[1:0].
  - byte = mem_rdata[8a+7:8a].
  - half = a[1] ? mem_rdata[31:16] : mem_rdata[15:0]; a[0] is ignored because aligned access is architecturally required.
  - ld_b: sign-extended byte. ld_bu: zero-extended byte.
  - ld_h: sign-extended half. ld_hu: zero-extended half.
  - ld_w, or res_from_mem with no size flag set: mem_rdata.
  - Size flags are one-hot. If several are set, priority is b > bu > h > hu > w.
- Result: final_result = res_from_mem ? load_data : exe_result.
- Latency: a load result is available combinationally in the same cycle the instruction occupies MEM, with no extra stall.
- Simultaneous events:
  - When WB accepts and EXE offers in the same cycle, the new payload replaces the old with no bubble; first_r=1 for the newcomer.
  - When WB accepts and EXE offers nothing, ms_valid=0 next cycle. bus_r keeps its value, but all forwarding outputs are gated.
- Reset mid-operation: reset wins over the handshake. The in-flight instruction is discarded and nothing is presented to WB.

Decomposition:
- Macros ES_TO_MS_BUS_WD and MS_TO_WS_BUS_WD go in the shared mycpu.h header, replacing any local literals.
- Sub-module mem_load_align (combinational): inputs mem_rdata, addr[1:0], five size flags; output load_data[31:0].

Test Plan:
- ld_b: rdata=0x80FF7F01, addr[1:0]=3, WB ready → final_result=0xFFFFFF80, gr_we=1, ms_to_ws_valid for 1 cycle.
- ld_bu at addr 3 and ld_hu at addr 2 with rdata=0x80FF7F01 → 0x00000080 and 0x000080FF. ld_h at addr 2 → 0xFFFF80FF.
- Load with ws_allowin=0 for 3 cycles; rdata changes to 0xDEADBEEF after the first cycle → result stays at first-cycle data; ms_allowin=0 throughout; result delivered when ws_allowin rises.
- Back-to-back: ALU op (exe_result=0x1234) then ld_w (rdata=0xCAFEF00D), WB always ready → consecutive outputs 0x1234 then 0xCAFEF00D, no bubble; MEM_dest tracks each dest.
- Empty stage with stale bus_r (dest=5, gr_we=1) after WB drain → MEM_dest=0, mem_gr_we=0.
- Reset asserted while a stalled load is in MEM → next cycle ms_to_ws_valid=0, MEM_dest=0, ms_allowin=1; no stale delivery after reset deasserts.
